// File: rtl/qeciphy_traffic_gen_chk_if.sv
// AXI-Stream beat bundle for the QECIPHY link-test generator and checker.
// The master drives data and valid; the slave returns ready.
interface qeciphy_traffic_gen_chk_if #(
  parameter int DATA_WIDTH = 64
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/qeciphy_traffic_gen_chk.sv
// Link-test traffic source (counter / PRBS-31) and self-synchronising checker
// with saturating error statistics, sitting directly on the QECIPHY AXI-Stream ports.
//
// state     | meaning
// ST_HUNT   | waiting for a beat to seed the expected-word register
// ST_LOCKED | comparing every beat against the tracked expected word
module qeciphy_traffic_gen_chk #(
  parameter int                    DATA_WIDTH  = 64,
  parameter logic [DATA_WIDTH-1:0] PRBS_SEED   = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter logic [DATA_WIDTH-1:0] CNT_SEED    = 64'h0,
  parameter int                    LOSS_THRESH = 8
) (
  input  logic                        i_aclk,
  input  logic                        i_arst,
  input  logic                        i_en,
  input  logic                        i_mode,
  input  logic                        i_clr,
  qeciphy_traffic_gen_chk_if.master   o_tx,
  qeciphy_traffic_gen_chk_if.slave    i_rx,
  output logic                        o_locked,
  output logic                        o_err,
  output logic [31:0]                 o_word_cnt,
  output logic [31:0]                 o_err_cnt,
  output logic [31:0]                 o_bit_err_cnt,
  output logic [15:0]                 o_loss_cnt
);

  localparam int         DW        = DATA_WIDTH;
  localparam logic [7:0] LP_THRESH = LOSS_THRESH[7:0];

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Next pattern word; the PRBS step expands 64 serial LFSR steps into one word.
  function automatic logic [DW-1:0] f_step(input logic [DW-1:0] w, input logic prbs);
    logic [2*DW-1:0] b;
    logic [DW-1:0]   res;
    b = {{DW{1'b0}}, w};
    for (int i = 0; i < DW; i++) begin
      b[DW+i] = b[DW+i-31] ^ b[DW+i-28];
    end
    if (prbs) begin
      res = b[2*DW-1:DW];
    end else begin
      res = w + {{(DW-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  logic [DW-1:0] r_tx_data;
  logic          r_tx_valid;
  logic          r_gen_mode;

  logic          w_tx_fire;

  assign w_tx_fire   = r_tx_valid & o_tx.tready;
  assign o_tx.tdata  = r_tx_data;
  assign o_tx.tvalid = r_tx_valid;

  always_ff @(posedge i_aclk or posedge i_arst) begin
    if (i_arst) begin
      r_tx_data  <= CNT_SEED;
      r_tx_valid <= 1'b0;
      r_gen_mode <= 1'b0;
    end else if (!i_en) begin
      // Disabled: reload the seed of the requested mode; a pending word is dropped.
      r_gen_mode <= i_mode;
      r_tx_data  <= i_mode ? PRBS_SEED : CNT_SEED;
      r_tx_valid <= 1'b0;
    end else begin
      r_tx_valid <= 1'b1;
      if (w_tx_fire) begin
        r_tx_data <= f_step(r_tx_data, r_gen_mode);
      end
    end
  end

  state_t        r_state;
  logic          r_locked;
  logic          r_chk_mode;
  logic [DW-1:0] r_exp;
  logic [7:0]    r_consec;
  logic          r_err;
  logic [31:0]   r_word_cnt;
  logic [31:0]   r_err_cnt;
  logic [31:0]   r_bit_err_cnt;
  logic [15:0]   r_loss_cnt;

  logic          w_beat;
  logic [DW-1:0] w_diff;
  logic          w_mismatch;
  logic [31:0]   w_popcnt;
  logic [32:0]   w_bit_sum;
  logic [7:0]    w_consec_nxt;
  logic          w_loss;

  assign i_rx.tready  = 1'b1;
  assign w_beat       = i_rx.tvalid;
  assign w_diff       = i_rx.tdata ^ r_exp;
  assign w_mismatch   = |w_diff;
  assign w_popcnt     = 32'($countones(w_diff));
  assign w_bit_sum    = {1'b0, r_bit_err_cnt} + {1'b0, w_popcnt};
  assign w_consec_nxt = r_consec + 8'd1;
  assign w_loss       = (w_consec_nxt == LP_THRESH);

  always_ff @(posedge i_aclk or posedge i_arst) begin
    if (i_arst) begin
      r_state       <= ST_HUNT;
      r_locked      <= 1'b0;
      r_chk_mode    <= 1'b0;
      r_exp         <= '0;
      r_consec      <= '0;
      r_err         <= 1'b0;
      r_word_cnt    <= '0;
      r_err_cnt     <= '0;
      r_bit_err_cnt <= '0;
      r_loss_cnt    <= '0;
    end else if (i_clr) begin
      // Clear wins over a same-cycle beat: it neither counts nor seeds.
      r_state       <= ST_HUNT;
      r_locked      <= 1'b0;
      r_chk_mode    <= i_mode;
      r_consec      <= '0;
      r_err         <= 1'b0;
      r_word_cnt    <= '0;
      r_err_cnt     <= '0;
      r_bit_err_cnt <= '0;
      r_loss_cnt    <= '0;
    end else begin
      case (r_state)
        ST_HUNT: begin
          r_chk_mode <= i_mode;
          if (w_beat) begin
            r_exp    <= f_step(i_rx.tdata, i_mode);
            r_state  <= ST_LOCKED;
            r_locked <= 1'b1;
            r_consec <= '0;
          end
        end
        ST_LOCKED: begin
          if (w_beat) begin
            r_word_cnt <= (&r_word_cnt) ? r_word_cnt : r_word_cnt + 32'd1;
            r_exp      <= f_step(r_exp, r_chk_mode);
            if (w_mismatch) begin
              r_err         <= 1'b1;
              r_err_cnt     <= (&r_err_cnt) ? r_err_cnt : r_err_cnt + 32'd1;
              r_bit_err_cnt <= w_bit_sum[32] ? 32'hFFFF_FFFF : w_bit_sum[31:0];
              if (w_loss) begin
                r_state    <= ST_HUNT;
                r_locked   <= 1'b0;
                r_loss_cnt <= (&r_loss_cnt) ? r_loss_cnt : r_loss_cnt + 16'd1;
                r_consec   <= '0;
              end else begin
                r_consec <= w_consec_nxt;
              end
            end else begin
              r_consec <= '0;
            end
          end
        end
        default: begin
          r_state  <= ST_HUNT;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign o_locked      = r_locked;
  assign o_err         = r_err;
  assign o_word_cnt    = r_word_cnt;
  assign o_err_cnt     = r_err_cnt;
  assign o_bit_err_cnt = r_bit_err_cnt;
  assign o_loss_cnt    = r_loss_cnt;

endmodule

// File: tb/tb_qeciphy_traffic_gen_chk.sv
// Directed bench for qeciphy_traffic_gen_chk: loopback runs, a table of checker
// vectors, backpressure, generator disable and asynchronous reset sequences.
module tb_qeciphy_traffic_gen_chk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst, en, mode, clr, tready, loop, drv_valid;
  logic [63:0] drv_data;
  logic        locked, err;
  logic [31:0] word_cnt, err_cnt, bit_err_cnt;
  logic [15:0] loss_cnt;

  qeciphy_traffic_gen_chk_if tx_if ();
  qeciphy_traffic_gen_chk_if rx_if ();

  assign tx_if.tready = tready;
  assign rx_if.tdata  = loop ? tx_if.tdata : drv_data;
  assign rx_if.tvalid = loop ? (tx_if.tvalid & tx_if.tready) : drv_valid;

  qeciphy_traffic_gen_chk dut (
    .i_aclk        (clk),
    .i_arst        (arst),
    .i_en          (en),
    .i_mode        (mode),
    .i_clr         (clr),
    .o_tx          (tx_if),
    .i_rx          (rx_if),
    .o_locked      (locked),
    .o_err         (err),
    .o_word_cnt    (word_cnt),
    .o_err_cnt     (err_cnt),
    .o_bit_err_cnt (bit_err_cnt),
    .o_loss_cnt    (loss_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serial LFSR model: shift in one x^31+x^28+1 bit at a time, newest bit at the top.
  function automatic logic [63:0] model_prbs(input logic [63:0] w);
    logic [63:0] h;
    logic        nb;
    h = w;
    for (int s = 0; s < 64; s++) begin
      nb = h[33] ^ h[36];
      h  = {nb, h[63:1]};
    end
    return h;
  endfunction

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic        clr;
    logic        lk;
    logic        er;
    int          ec;
    int          bc;
    int          ls;
    int          wc;
  } vec_t;

  vec_t        vec[27];
  int          bad, lk_bad, stable_bad, seq_bad, acc_n;
  logic [63:0] m, acc_exp, prev_d;
  logic        prev_stall;

  initial begin
    // Counter-mode checker vectors: {valid, data, clr, locked, err, err_cnt, bit_err_cnt, loss_cnt, word_cnt}
    vec[0]  = '{1'b1, 64'd100,    1'b0, 1'b1, 1'b0, 0,  0,   0, 0};
    vec[1]  = '{1'b1, 64'd101,    1'b0, 1'b1, 1'b0, 0,  0,   0, 1};
    vec[2]  = '{1'b0, 64'd0,      1'b0, 1'b1, 1'b0, 0,  0,   0, 1};
    vec[3]  = '{1'b1, 64'd103,    1'b0, 1'b1, 1'b1, 1,  1,   0, 2};
    vec[4]  = '{1'b1, 64'd103,    1'b0, 1'b1, 1'b1, 1,  1,   0, 3};
    vec[5]  = '{1'b1, 64'hFF68,   1'b0, 1'b1, 1'b1, 2,  9,   0, 4};
    vec[6]  = '{1'b1, 64'd105,    1'b0, 1'b1, 1'b1, 2,  9,   0, 5};
    vec[7]  = '{1'b1, 64'd0,      1'b0, 1'b1, 1'b1, 3,  13,  0, 6};
    vec[8]  = '{1'b1, 64'd0,      1'b0, 1'b1, 1'b1, 4,  18,  0, 7};
    vec[9]  = '{1'b1, 64'd0,      1'b0, 1'b1, 1'b1, 5,  22,  0, 8};
    vec[10] = '{1'b1, 64'd0,      1'b0, 1'b1, 1'b1, 6,  27,  0, 9};
    vec[11] = '{1'b1, 64'd0,      1'b0, 1'b1, 1'b1, 7,  32,  0, 10};
    vec[12] = '{1'b1, 64'd0,      1'b0, 1'b1, 1'b1, 8,  38,  0, 11};
    vec[13] = '{1'b1, 64'd0,      1'b0, 1'b1, 1'b1, 9,  41,  0, 12};
    vec[14] = '{1'b1, 64'd0,      1'b0, 1'b0, 1'b1, 10, 45,  1, 13};
    vec[15] = '{1'b1, 64'd500,    1'b0, 1'b1, 1'b1, 10, 45,  1, 13};
    vec[16] = '{1'b1, 64'd0,      1'b0, 1'b1, 1'b1, 11, 52,  1, 14};
    vec[17] = '{1'b1, 64'd0,      1'b0, 1'b1, 1'b1, 12, 59,  1, 15};
    vec[18] = '{1'b1, 64'd0,      1'b0, 1'b1, 1'b1, 13, 67,  1, 16};
    vec[19] = '{1'b1, 64'd0,      1'b0, 1'b1, 1'b1, 14, 73,  1, 17};
    vec[20] = '{1'b1, 64'd0,      1'b0, 1'b1, 1'b1, 15, 80,  1, 18};
    vec[21] = '{1'b1, 64'd0,      1'b0, 1'b1, 1'b1, 16, 87,  1, 19};
    vec[22] = '{1'b1, 64'd0,      1'b0, 1'b1, 1'b1, 17, 95,  1, 20};
    vec[23] = '{1'b1, 64'd508,    1'b0, 1'b1, 1'b1, 17, 95,  1, 21};
    vec[24] = '{1'b1, 64'd0,      1'b0, 1'b1, 1'b1, 18, 103, 1, 22};
    vec[25] = '{1'b1, 64'd510,    1'b1, 1'b0, 1'b0, 0,  0,   0, 0};
    vec[26] = '{1'b0, 64'd0,      1'b0, 1'b0, 1'b0, 0,  0,   0, 0};

    arst = 1'b1; en = 1'b0; mode = 1'b0; clr = 1'b0; tready = 1'b1;
    loop = 1'b0; drv_valid = 1'b0; drv_data = '0;
    step(); step();
    check("rst_tvalid",   tx_if.tvalid, 0);
    check("rst_tdata",    tx_if.tdata, 0);
    check("rst_rx_ready", rx_if.tready, 1);
    check("rst_locked",   locked, 0);
    check("rst_err",      err, 0);
    check("rst_counters", {word_cnt, err_cnt} | {bit_err_cnt, 16'h0, loss_cnt}, 0);
    arst = 1'b0;
    step();

    // Counter loopback, 1000 beats
    en = 1'b1; loop = 1'b1;
    step();
    bad = 0; lk_bad = 0;
    for (int k = 0; k < 1000; k++) begin
      if (tx_if.tvalid !== 1'b1 || tx_if.tdata !== 64'(k)) bad++;
      if (k == 1) check("cnt_locked_after_beat1", locked, 1);
      if (k >= 1 && locked !== 1'b1) lk_bad++;
      step();
    end
    loop = 1'b0; en = 1'b0;
    check("cnt_sequence",  bad, 0);
    check("cnt_lock_held", lk_bad, 0);
    check("cnt_word_cnt",  word_cnt, 999);
    check("cnt_err_cnt",   err_cnt, 0);
    check("cnt_err",       err, 0);

    // PRBS loopback, 1000 beats
    mode = 1'b1; clr = 1'b1;
    step();
    clr = 1'b0;
    check("prbs_reload_seed", tx_if.tdata, 64'hFFFF_FFFF_FFFF_FFFF);
    check("clr_to_hunt",      locked, 0);
    en = 1'b1; loop = 1'b1;
    step();
    m = 64'hFFFF_FFFF_FFFF_FFFF; bad = 0; lk_bad = 0;
    for (int k = 0; k < 1000; k++) begin
      if (tx_if.tdata !== m) bad++;
      if (k == 1) check("prbs_word1", tx_if.tdata, model_prbs(64'hFFFF_FFFF_FFFF_FFFF));
      if (k >= 1 && locked !== 1'b1) lk_bad++;
      m = model_prbs(m);
      step();
    end
    loop = 1'b0; en = 1'b0;
    check("prbs_sequence",  bad, 0);
    check("prbs_lock_held", lk_bad, 0);
    check("prbs_err_cnt",   err_cnt, 0);
    check("prbs_word_cnt",  word_cnt, 999);

    // Checker vector table, counter mode, RX driven directly
    mode = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 27; i++) begin
      drv_valid = vec[i].v; drv_data = vec[i].d; clr = vec[i].clr;
      step();
      check($sformatf("vec%0d_locked",  i), locked,      vec[i].lk);
      check($sformatf("vec%0d_err",     i), err,         vec[i].er);
      check($sformatf("vec%0d_err_cnt", i), err_cnt,     vec[i].ec);
      check($sformatf("vec%0d_bit_cnt", i), bit_err_cnt, vec[i].bc);
      check($sformatf("vec%0d_loss",    i), loss_cnt,    vec[i].ls);
      check($sformatf("vec%0d_word",    i), word_cnt,    vec[i].wc);
    end
    drv_valid = 1'b0; clr = 1'b0;

    // Random backpressure on the generator
    en = 1'b1;
    step();
    acc_exp = '0; prev_d = '0; prev_stall = 1'b0;
    stable_bad = 0; seq_bad = 0; acc_n = 0;
    for (int c = 0; c < 300; c++) begin
      if (prev_stall && tx_if.tdata !== prev_d) stable_bad++;
      tready = 1'($urandom_range(0, 1));
      if (tx_if.tvalid && tready) begin
        if (tx_if.tdata !== acc_exp) seq_bad++;
        acc_exp = acc_exp + 64'd1;
        acc_n++;
      end
      prev_stall = tx_if.tvalid & ~tready;
      prev_d     = tx_if.tdata;
      step();
    end
    check("bp_stable_when_stalled", stable_bad, 0);
    check("bp_accepted_consecutive", seq_bad, 0);
    check("bp_some_accepted", (acc_n > 0), 1);
    check("bp_next_word", tx_if.tdata, acc_exp);

    // EN falls while a word is pending
    tready = 1'b0;
    step();
    en = 1'b0;
    step();
    check("en_drop_tvalid", tx_if.tvalid, 0);
    check("en_drop_reload", tx_if.tdata, 0);
    tready = 1'b1;

    // ARST during loopback traffic
    clr = 1'b1;
    step();
    clr = 1'b0; en = 1'b1; loop = 1'b1;
    step();
    for (int c = 0; c < 20; c++) step();
    check("pre_arst_locked",   locked, 1);
    check("pre_arst_word_cnt", word_cnt, 19);
    arst = 1'b1;
    #1;
    check("arst_async_tvalid", tx_if.tvalid, 0);
    check("arst_async_tdata",  tx_if.tdata, 0);
    check("arst_async_locked", locked, 0);
    check("arst_async_word",   word_cnt, 0);
    step();
    check("arst_held_tvalid", tx_if.tvalid, 0);
    check("arst_held_stats",  {word_cnt, err_cnt} | {bit_err_cnt, 16'h0, loss_cnt}, 0);
    arst = 1'b0;
    step(); step(); step();
    check("post_arst_locked",   locked, 1);
    check("post_arst_word_cnt", word_cnt, 1);
    check("post_arst_err_cnt",  err_cnt, 0);
    loop = 1'b0; en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
